score_seg_display: RTL
======================

Name: score_seg_display

Overview:
- Downstream consumer of the game core's score; drives the board's 4-digit seven-segment display (`seg_select`, `seg_LED`) on the `oriclk` domain.
- Converts a 14-bit binary score to 4 BCD digits with a sequential shift-add-3 engine, then time-multiplexes the digits.
- Replaces ad-hoc score display logic inside the `flappybird` top level; instantiated there alongside the VGA path.

Parameters:
- SCAN_DIV, 100000, `oriclk` cycles each digit stays selected (1 kHz per digit at 100 MHz); legal range 2..2^20.

Ports:
- oriclk  input  1  system clock, all logic rising-edge.
- rst  input  1  asynchronous, active-low reset; low forces reset state immediately, release is synchronous to `oriclk`.
- score  input  14  binary score from game core.
- score_valid  input  1  single-cycle strobe: sample `score`.
- blank  input  1  high = display dark (seg outputs off); scanning continues.
- busy  output  1  high while a conversion is in progress or pending.
- seg_select  output  4  digit enables, active-low; bit0 = units (rightmost), bit3 = thousands.
- seg_LED  output  7  segments, active-low, {g,f,e,d,c,b,a}.

Behaviour:
- Reset values:
  - `seg_select` = 4'b1111, `seg_LED` = 7'b1111111, `busy` = 0.
  - Displayed BCD = 0000, digit index = 0, scan counter = 0, FSM = IDLE, pending flag = 0.
  - First scan after release shows "0000".
- Saturation: `score` > 9999 is clamped to 9999 at capture time.
- Conversion FSM, states IDLE and SHIFT:
  - IDLE, `score_valid`=1 at edge t: capture clamped value, clear BCD accumulator and shift count, go to SHIFT, `busy`=1 from t.
  - SHIFT: each edge adds 3 to every BCD nibble >= 5, then shifts {bcd, bin} left by 1. This repeats for 14 edges (t+1..t+14).
  - On edge t+14 the 16-bit result is written atomically into the displayed BCD register.
  - Same edge t+14, no pending: FSM goes to IDLE and `busy` drops to 0.
  - Same edge t+14, pending set: recapture the pending value, restart SHIFT, `busy` stays 1.
  - `score_valid` while in SHIFT stores the clamped value into the pending register and sets pending. Latest strobe wins; the running conversion is not disturbed.
  - `score_valid` on the completion edge itself is treated as pending.
  - Displayed value never shows a partial conversion.
- Scan timing:
  - Scan counter runs 0..SCAN_DIV-1 continuously.
  - At terminal count the counter wraps to 0 and the digit index increments mod 4 (0→1→2→3→0).
- Output registering:
  - Outputs are registered and reflect the digit index one cycle after it changes.
  - `seg_select` = ~(1 << index).
  - `seg_LED` = encoding of the indexed BCD nibble.
  - A new displayed value shows on the next output registration edge.
- Encoding (active-low hex):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - Any nibble >9 (unreachable) gives 7F.
- `blank`=1: next registered outputs are `seg_select`=1111 and `seg_LED`=1111111. Index and counter keep running; display resumes at the current index when `blank` falls.
- `rst` asserted mid-conversion: conversion aborted, pending discarded, displayed value returns to 0000.

Optional Feature:
- Macro `SEG_LZ_BLANK_EN`.
- Defined: leading-zero blanking. A digit position above the most significant non-zero digit drives `seg_select` bit high (off) and `seg_LED` = 7F during its slot. The units digit is always shown, so score 0 shows "0" and 0042 shows "42".
- Undefined: all four digits always shown, including leading zeros.

Test Plan:
- Reset: hold `rst`=0 with `score_valid` toggling → `seg_select`=1111, `seg_LED`=7F, `busy`=0. Release with SCAN_DIV=4 → units slot shows 1110/40 and all slots show 40.
- Single conversion: `score`=1234 strobed at t → `busy`=1 for exactly 14 cycles, 0 after t+14. Scan then yields slot 1110/19, 1101/30, 1011/24, 0111/79.
- Saturation: `score`=12000 → all four digits 10 (9). `score`=16383 → same.
- Back-to-back: strobe 0005 at t, 0777 at t+3, 0100 at t+8 → `busy` continuous for 28 cycles. No intermediate 0777 ever displayed; final display 0100.
- Blank and mid-op reset:
  - `blank`=1 for 10 cycles → outputs 1111/7F throughout, then index continues in sequence.
  - `rst` pulsed low at t+7 of a 4321 conversion → display returns to 0000 and `busy`=0.
- With `SEG_LZ_BLANK_EN`: `score`=7 → only 1110/78 driven; other slots 1111/7F. `score`=0 → units shows 40.

Source files
------------

// File: rtl/score_seg_display.sv
// -----------------------------------------------------------------------------
// score_seg_display
//
// Shows the game score on the board's 4-digit seven-segment display.
// A 14-bit binary score is saturated to 9999. A sequential shift-add-3
// (double-dabble) engine then converts it to four BCD digits, and the digits
// are time-multiplexed onto the display.
//
// Parameters:
//   SCAN_DIV     oriclk cycles each digit stays selected (2 .. 2^20)
//
// Ports:
//   oriclk       in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   score[13:0]  in   binary score from the game core
//   score_valid  in   single-cycle strobe, sample score
//   blank        in   1 = display dark, scanning keeps running
//   busy         out  conversion in progress or pending
//   seg_select   out  digit enables, active-low, bit0 = units
//   seg_LED      out  segments, active-low, {g,f,e,d,c,b,a}
//
// Optional build macro:
//   SEG_LZ_BLANK_EN  leading-zero blanking (units digit always shown)
// -----------------------------------------------------------------------------
module score_seg_display #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        oriclk,
    input  logic        rst,
    input  logic [13:0] score,
    input  logic        score_valid,
    input  logic        blank,
    output logic        busy,
    output logic [3:0]  seg_select,
    output logic [6:0]  seg_LED
);

    localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    // Saturate the incoming score to the largest 4-digit value.
    function automatic logic [13:0] clamp_score(input logic [13:0] v);
        return (v > 14'd9999) ? 14'd9999 : v;
    endfunction

    // One double-dabble step on {bcd[15:0], bin[13:0]}: every BCD nibble
    // >= 5 gets +3, then the whole vector shifts left by one.
    function automatic logic [29:0] dabble_step(input logic [29:0] v);
        logic [29:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[14 + 4*i +: 4] >= 4'd5) begin
                t[14 + 4*i +: 4] = t[14 + 4*i +: 4] + 4'd3;
            end
        end
        return t << 1;
    endfunction

    // Active-low {g,f,e,d,c,b,a}. Nibbles above 9 cannot occur; they go dark.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Conversion state
    state_t      state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] acc_q, acc_d;
    logic [3:0]  shcnt_q, shcnt_d;
    logic        pend_q, pend_d;
    logic [13:0] pend_val_q, pend_val_d;
    logic [15:0] disp_q, disp_d;
    logic [29:0] step;

    // Scan and output state
    logic [CNT_W-1:0] scan_q, scan_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       sel_q, sel_d;
    logic [6:0]       led_q, led_d;
    logic             show;

    // -------------------------------------------------------------------------
    // Conversion FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        acc_d      = acc_q;
        shcnt_d    = shcnt_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        disp_d     = disp_q;
        step       = dabble_step({acc_q, bin_q});

        case (state_q)
            IDLE: begin
                if (score_valid) begin
                    bin_d   = clamp_score(score);
                    acc_d   = '0;
                    shcnt_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                acc_d   = step[29:14];
                bin_d   = step[13:0];
                shcnt_d = shcnt_q + 4'd1;
                // A strobe during a conversion, including on its final edge,
                // is parked; the latest one wins.
                if (score_valid) begin
                    pend_d     = 1'b1;
                    pend_val_d = clamp_score(score);
                end
                if (shcnt_q == 4'd13) begin
                    // 14th shift: publish the whole result in one go.
                    disp_d = step[29:14];
                    if (score_valid || pend_q) begin
                        bin_d   = score_valid ? clamp_score(score) : pend_val_q;
                        acc_d   = '0;
                        shcnt_d = '0;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Digit scan and registered outputs: next state
    // -------------------------------------------------------------------------
    always_comb begin
        scan_d = scan_q + CNT_ONE;
        idx_d  = idx_q;
        if (scan_q == CNT_LAST) begin
            scan_d = '0;
            idx_d  = idx_q + 2'd1;
        end

`ifdef SEG_LZ_BLANK_EN
        // Show a digit only if it or a more significant digit is non-zero;
        // the units position is always lit.
        show = (idx_q == 2'd0) || ((disp_q >> {idx_q, 2'b00}) != 16'd0);
`else
        show = 1'b1;
`endif

        if (blank || !show) begin
            sel_d = 4'b1111;
            led_d = 7'h7F;
        end else begin
            sel_d = ~(4'b0001 << idx_q);
            led_d = seg_encode(disp_q[{idx_q, 2'b00} +: 4]);
        end
    end

    // -------------------------------------------------------------------------
    // Registers with reset
    // -------------------------------------------------------------------------
    always_ff @(posedge oriclk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shcnt_q <= '0;
            pend_q  <= 1'b0;
            disp_q  <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            sel_q   <= 4'b1111;
            led_q   <= 7'h7F;
        end else begin
            state_q <= state_d;
            shcnt_q <= shcnt_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            led_q   <= led_d;
        end
    end

    // Datapath registers; always reloaded before use, so no reset needed.
    always_ff @(posedge oriclk) begin
        bin_q      <= bin_d;
        acc_q      <= acc_d;
        pend_val_q <= pend_val_d;
    end

    assign busy       = (state_q == SHIFT);
    assign seg_select = sel_q;
    assign seg_LED    = led_q;

endmodule
